// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Sequencer states and forward-select encodings.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forward-source select for one ALU operand.
// Newest producer (EX) wins over MEM; loads in EX cannot forward.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_v,
  input  logic              bubble,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wb,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wb,
  output logic [1:0]        fwd_sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_wb & ~ex_mem_read & (ex_rd == rs);
  assign mem_hit = mem_wb & (mem_rd == rs);

  // pick the youngest in-flight producer of rs
  always_comb begin
    fwd_sel = FWD_REG;
    if (rs_v && !bubble) begin
      if (ex_hit)       fwd_sel = FWD_EXMEM;
      else if (mem_hit) fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing control for the 5-stage pipeline.
// Load/drain sequencer, jump flush, load-use stall, forwarding.
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = 3,
  parameter int FLUSH_CYC = 1,
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_mode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_v,
  input  logic              id_rs2_v,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wb,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wb,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wb,
  input  logic              jump_taken_ex,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int CMAX =
    (DRAIN_CYC > FLUSH_CYC) ? DRAIN_CYC : FLUSH_CYC;
  localparam int CBW = $clog2(CMAX + 1);

  localparam logic [CBW-1:0] C_ONE   = CBW'(1);
  localparam logic [CBW-1:0] C_DRAIN = CBW'(DRAIN_CYC);
  localparam logic [CBW-1:0] C_FLUSH = CBW'(FLUSH_CYC);

  ctrl_state_t    state_q;
  ctrl_state_t    state_d;
  logic [CBW-1:0] cnt_q;
  logic [CBW-1:0] cnt_d;
  logic           stall_inc;
  logic           flush_inc;
  logic           load_use;

  // WB writes land in the regfile before decode needs them,
  // and a load in MEM is already forwardable from MEM-WB.
  logic unused_inputs;
  assign unused_inputs = ^{wb_rd, wb_wb, mem_mem_read};

  assign load_use = ex_mem_read & ex_wb &
    ((id_rs1_v & (id_rs1 == ex_rd)) |
     (id_rs2_v & (id_rs2 == ex_rd)));

  // sequencer next state and same-cycle pipeline controls
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        pc_stall    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (!load_mode) begin
          state_d = ST_DRAIN;
          cnt_d   = C_DRAIN;
        end
      end
      ST_DRAIN: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (cnt_q == C_ONE) state_d = ST_RUN;
        else                cnt_d   = cnt_q - C_ONE;
        if (load_mode) state_d = ST_LOAD;
      end
      ST_RUN: begin
        if (jump_taken_ex) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          if (FLUSH_CYC > 0) begin
            state_d = ST_FLUSH;
            cnt_d   = C_FLUSH;
          end
        end else if (load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end
        if (load_mode) state_d = ST_LOAD;
      end
      ST_FLUSH: begin
        ifid_flush = 1'b1;
        if (jump_taken_ex) begin
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          cnt_d       = C_FLUSH;
        end else if (cnt_q == C_ONE) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
        if (load_mode) state_d = ST_LOAD;
      end
    endcase
  end

  // state, down-counter and saturating debug counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= load_mode ? ST_LOAD : ST_DRAIN;
      cnt_q     <= C_DRAIN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs          (id_rs1),
    .rs_v        (id_rs1_v),
    .bubble      (idex_bubble),
    .ex_rd       (ex_rd),
    .ex_wb       (ex_wb),
    .ex_mem_read (ex_mem_read),
    .mem_rd      (mem_rd),
    .mem_wb      (mem_wb),
    .fwd_sel     (fwd_a)
  );

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs          (id_rs2),
    .rs_v        (id_rs2_v),
    .bubble      (idex_bubble),
    .ex_rd       (ex_rd),
    .ex_wb       (ex_wb),
    .ex_mem_read (ex_mem_read),
    .mem_rd      (mem_rd),
    .mem_wb      (mem_wb),
    .fwd_sel     (fwd_b)
  );

endmodule
